// File: rtl/ift_arb_pkg.sv
// ---------------------------------------------------------------------------
// ift_arb_pkg
//
// Shared definitions for the information-flow-tracking latch arbiter.
//
// Contents:
//   arbState_e  - arbiter FSM states (IDLE, OWN, CLEAR)
//   DEFAULT_TW  - default taint tag width used by the arbiter and picker
// ---------------------------------------------------------------------------
package ift_arb_pkg;

    // Arbiter FSM states.
    //   IDLE  : no owner, waiting for a request or a clear
    //   OWN   : one requester holds the shared storage and writes it each cycle
    //   CLEAR : single cycle that loads the clear value into the storage
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        CLEAR = 2'd2
    } arbState_e;

    // Default width of every taint tag.
    localparam int DEFAULT_TW = 32;

endpackage

// File: rtl/ift_rr_pick.sv
// ---------------------------------------------------------------------------
// ift_rr_pick
//
// Combinational round-robin picker with taint aggregation.
//
// The winner is the first set request bit at or after the pointer, wrapping
// from NREQ-1 back to 0. The taint output is the OR of the request taints of
// every requester that is currently asserting, because the grant decision
// depends on all of them, not only on the winner.
//
// Ports:
//   req_i    [NREQ-1:0]     request vector, one bit per requester
//   reqT_i   [NREQ*TW-1:0]  request taints, slice i belongs to requester i
//   ptr_i    [IW-1:0]       round-robin starting position
//   valid_o                 at least one request is set
//   owner_o  [IW-1:0]       index of the chosen requester
//   taint_o  [TW-1:0]       OR of taints of all asserted requests
// ---------------------------------------------------------------------------
module ift_rr_pick
    import ift_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TW   = DEFAULT_TW,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*TW-1:0] reqT_i,
    input  logic [IW-1:0]      ptr_i,
    output logic               valid_o,
    output logic [IW-1:0]      owner_o,
    output logic [TW-1:0]      taint_o
);

    // Two passes give the wrap-around search without a modulo: the first
    // pass only considers positions at or above the pointer, the second pass
    // (reached only if nothing was found) considers positions below it.
    always_comb begin
        valid_o = 1'b0;
        owner_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!valid_o && req_i[i] && (i >= int'(ptr_i))) begin
                valid_o = 1'b1;
                owner_o = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!valid_o && req_i[i] && (i < int'(ptr_i))) begin
                valid_o = 1'b1;
                owner_o = IW'(i);
            end
        end
    end

    // Taint of the decision: every asserted request influenced who won.
    always_comb begin
        taint_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_i[i]) begin
                taint_o = taint_o | reqT_i[i*TW +: TW];
            end
        end
    end

endmodule

// File: rtl/ift_latch_arbiter.sv
// ---------------------------------------------------------------------------
// ift_latch_arbiter
//
// Round-robin arbiter guarding one shared storage word, with taint tracking.
// A granted requester writes its data slice into the storage every cycle of
// its tenure; the tenure ends when it drops its request, when it has written
// MAX_HOLD times, or when a clear preempts it. A clear loads CLR_VALUE.
//
// Parameters:
//   NREQ      number of requesters (2..8)
//   WIDTH     storage data width
//   TW        taint tag width
//   CLR_VALUE value loaded into the storage on clear
//   MAX_HOLD  maximum tenure length in cycles (>= 1)
//
// Ports:
//   CLK    [1]           clock, all state changes on rising edge
//   SRST   [1]           synchronous active-high reset
//   REQ    [NREQ]        request vector
//   REQ_t  [NREQ*TW]     taint per request bit
//   D      [NREQ*WIDTH]  write data per requester
//   D_t    [NREQ*TW]     taint per data slice
//   CLR    [1]           clear request
//   CLR_t  [TW]          taint of CLR
//   GNT    [NREQ]        registered one-hot grant
//   GNT_t  [TW]          taint of the grant decision
//   Q      [WIDTH]       shared storage value
//   Q_t    [TW]          taint of Q
//   BUSY   [1]           state is not IDLE
// ---------------------------------------------------------------------------
module ift_latch_arbiter
    import ift_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 2,
    parameter int TW        = DEFAULT_TW,
    parameter int CLR_VALUE = 3,
    parameter int MAX_HOLD  = 8
) (
    input  logic                  CLK,
    input  logic                  SRST,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*TW-1:0]    REQ_t,
    input  logic [NREQ*WIDTH-1:0] D,
    input  logic [NREQ*TW-1:0]    D_t,
    input  logic                  CLR,
    input  logic [TW-1:0]         CLR_t,
    output logic [NREQ-1:0]       GNT,
    output logic [TW-1:0]         GNT_t,
    output logic [WIDTH-1:0]      Q,
    output logic [TW-1:0]         Q_t,
    output logic                  BUSY
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_HOLD + 1);

    localparam logic [WIDTH-1:0] CLR_WORD = WIDTH'(CLR_VALUE);
    localparam logic [IW-1:0]    LAST_IDX = IW'(NREQ - 1);
    localparam logic [CW-1:0]    LAST_CNT = CW'(MAX_HOLD - 1);
    localparam logic [NREQ-1:0]  ONE_GNT  = NREQ'(1);

    // Architectural state
    arbState_e         state_q,    state_d;
    logic [IW-1:0]     ptr_q,      ptr_d;
    logic [IW-1:0]     owner_q,    owner_d;
    logic [CW-1:0]     cnt_q,      cnt_d;
    logic              preempt_q,  preempt_d;
    logic [NREQ-1:0]   gnt_q,      gnt_d;
    logic [TW-1:0]     gntTaint_q, gntTaint_d;
    logic [WIDTH-1:0]  store_q,    store_d;
    logic [TW-1:0]     storeT_q,   storeT_d;
    logic              busy_q,     busy_d;

    // Picker results
    logic              pickValid;
    logic [IW-1:0]     pickOwner;
    logic [TW-1:0]     pickTaint;

    // Per-requester views of the flattened input buses
    logic [WIDTH-1:0]  dSlice    [NREQ];
    logic [TW-1:0]     dTSlice   [NREQ];
    logic [TW-1:0]     reqTSlice [NREQ];

    // Values belonging to the current owner
    logic [WIDTH-1:0]  ownerData;
    logic [TW-1:0]     ownerDataT;
    logic [TW-1:0]     ownerReqT;
    logic              ownerReq;
    logic [IW-1:0]     afterOwner;

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign dSlice[g]    = D[g*WIDTH +: WIDTH];
        assign dTSlice[g]   = D_t[g*TW +: TW];
        assign reqTSlice[g] = REQ_t[g*TW +: TW];
    end

    ift_rr_pick #(
        .NREQ (NREQ),
        .TW   (TW),
        .IW   (IW)
    ) u_pick (
        .req_i   (REQ),
        .reqT_i  (REQ_t),
        .ptr_i   (ptr_q),
        .valid_o (pickValid),
        .owner_o (pickOwner),
        .taint_o (pickTaint)
    );

    // The owner index stays valid during the CLEAR that follows a
    // preemption, so the clear path can still look at the old owner's data.
    assign ownerData  = dSlice[owner_q];
    assign ownerDataT = dTSlice[owner_q];
    assign ownerReqT  = reqTSlice[owner_q];
    assign ownerReq   = REQ[owner_q];

    // Whoever releases, the search restarts just past them.
    assign afterOwner = (owner_q == LAST_IDX) ? '0 : owner_q + IW'(1);

    // Next-state logic. Every register holds by default; each state only
    // spells out what it changes. All three ways out of OWN reset the
    // round-robin pointer past the owner and drop the grant and its taint.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        preempt_d  = preempt_q;
        gnt_d      = gnt_q;
        gntTaint_d = gntTaint_q;
        store_d    = store_q;
        storeT_d   = storeT_q;

        case (state_q)
            IDLE: begin
                gnt_d      = '0;
                gntTaint_d = '0;
                preempt_d  = 1'b0;
                if (CLR) begin
                    state_d = CLEAR;
                end else if (pickValid) begin
                    state_d    = OWN;
                    owner_d    = pickOwner;
                    cnt_d      = '0;
                    gnt_d      = ONE_GNT << pickOwner;
                    gntTaint_d = pickTaint;
                end
            end

            OWN: begin
                if (CLR) begin
                    state_d    = CLEAR;
                    preempt_d  = 1'b1;
                    ptr_d      = afterOwner;
                    gnt_d      = '0;
                    gntTaint_d = '0;
                end else if (!ownerReq) begin
                    state_d    = IDLE;
                    ptr_d      = afterOwner;
                    gnt_d      = '0;
                    gntTaint_d = '0;
                end else begin
                    // Data containing unknown bits carries no trustworthy
                    // flow information, so its taint is dropped.
                    store_d  = ownerData;
                    storeT_d = $isunknown(ownerData) ? '0
                             : (ownerDataT | gntTaint_q | ownerReqT);
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d    = IDLE;
                        ptr_d      = afterOwner;
                        gnt_d      = '0;
                        gntTaint_d = '0;
                    end
                end
            end

            CLEAR: begin
                // If the preempted owner was presenting exactly the clear
                // value, its data taint flows into the cleared word too.
                state_d   = IDLE;
                preempt_d = 1'b0;
                store_d   = CLR_WORD;
                storeT_d  = CLR_t
                          | ((preempt_q && (ownerData == CLR_WORD)) ? ownerDataT : '0);
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // BUSY is registered from the next state so that it lines up with the
    // state register without a combinational path to the output.
    assign busy_d = (state_d != IDLE);

    // State registers with synchronous reset taking priority over all else.
    always_ff @(posedge CLK) begin
        if (SRST) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            preempt_q  <= 1'b0;
            gnt_q      <= '0;
            gntTaint_q <= '0;
            store_q    <= '0;
            storeT_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            preempt_q  <= preempt_d;
            gnt_q      <= gnt_d;
            gntTaint_q <= gntTaint_d;
            store_q    <= store_d;
            storeT_q   <= storeT_d;
            busy_q     <= busy_d;
        end
    end

    assign GNT   = gnt_q;
    assign GNT_t = gntTaint_q;
    assign Q     = store_q;
    assign Q_t   = storeT_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_ift_latch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ift_latch_arbiter
//
// Self-checking bench for ift_latch_arbiter. A behavioural model tracks the
// current owner as an integer (-1 when nobody owns), counts writes per
// tenure and produces the expected outputs after every clock edge. Directed
// sequences cover the documented scenarios, then random traffic follows.
// ---------------------------------------------------------------------------
module tb_ift_latch_arbiter;

    localparam int NREQ      = 4;
    localparam int WIDTH     = 2;
    localparam int TW        = 32;
    localparam int CLR_VALUE = 3;
    localparam int MAX_HOLD  = 8;

    logic                  CLK;
    logic                  SRST;
    logic [NREQ-1:0]       REQ;
    logic [NREQ*TW-1:0]    REQ_t;
    logic [NREQ*WIDTH-1:0] D;
    logic [NREQ*TW-1:0]    D_t;
    logic                  CLR;
    logic [TW-1:0]         CLR_t;
    logic [NREQ-1:0]       GNT;
    logic [TW-1:0]         GNT_t;
    logic [WIDTH-1:0]      Q;
    logic [TW-1:0]         Q_t;
    logic                  BUSY;

    int compared;
    int mismatched;

    // Reference model state
    int               mOwner;
    int               mStart;
    int               mWrites;
    int               mPreemptOwner;
    bit               mClear;
    bit               mPreempt;
    logic [NREQ-1:0]  eGnt;
    logic [TW-1:0]    eGntT;
    logic [WIDTH-1:0] eQ;
    logic [TW-1:0]    eQT;
    logic             eBusy;

    ift_latch_arbiter #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .TW        (TW),
        .CLR_VALUE (CLR_VALUE),
        .MAX_HOLD  (MAX_HOLD)
    ) dut (
        .CLK   (CLK),
        .SRST  (SRST),
        .REQ   (REQ),
        .REQ_t (REQ_t),
        .D     (D),
        .D_t   (D_t),
        .CLR   (CLR),
        .CLR_t (CLR_t),
        .GNT   (GNT),
        .GNT_t (GNT_t),
        .Q     (Q),
        .Q_t   (Q_t),
        .BUSY  (BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [WIDTH-1:0] dOf(input int i);
        return D[i*WIDTH +: WIDTH];
    endfunction

    function automatic logic [TW-1:0] dtOf(input int i);
        return D_t[i*TW +: TW];
    endfunction

    function automatic logic [TW-1:0] rtOf(input int i);
        return REQ_t[i*TW +: TW];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mOwner        = -1;
        mStart        = 0;
        mWrites       = 0;
        mPreemptOwner = 0;
        mClear        = 1'b0;
        mPreempt      = 1'b0;
        eGnt          = '0;
        eGntT         = '0;
        eQ            = '0;
        eQT           = '0;
        eBusy         = 1'b0;
    endtask

    task automatic releaseOwner();
        mStart = (mOwner + 1) % NREQ;
        mOwner = -1;
        eGnt   = '0;
        eGntT  = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        int            w;
        logic [TW-1:0] t;
        w = -1;
        t = '0;
        if (SRST) begin
            modelReset();
        end else if (mClear) begin
            eQ  = WIDTH'(CLR_VALUE);
            eQT = CLR_t;
            if (mPreempt && (dOf(mPreemptOwner) == WIDTH'(CLR_VALUE)))
                eQT = eQT | dtOf(mPreemptOwner);
            mClear   = 1'b0;
            mPreempt = 1'b0;
            eBusy    = 1'b0;
        end else if (mOwner < 0) begin
            if (CLR) begin
                mClear   = 1'b1;
                mPreempt = 1'b0;
                eBusy    = 1'b1;
            end else if (REQ != '0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && REQ[(mStart + k) % NREQ]) w = (mStart + k) % NREQ;
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (REQ[i]) t = t | rtOf(i);
                end
                mOwner  = w;
                mWrites = 0;
                eGnt    = NREQ'(1) << w;
                eGntT   = t;
                eBusy   = 1'b1;
            end else begin
                eBusy = 1'b0;
            end
        end else begin
            if (CLR) begin
                mPreemptOwner = mOwner;
                mPreempt      = 1'b1;
                mClear        = 1'b1;
                releaseOwner();
                eBusy = 1'b1;
            end else if (!REQ[mOwner]) begin
                releaseOwner();
                eBusy = 1'b0;
            end else begin
                eQ  = dOf(mOwner);
                eQT = $isunknown(dOf(mOwner)) ? '0
                    : (dtOf(mOwner) | eGntT | rtOf(mOwner));
                mWrites++;
                if (mWrites == MAX_HOLD) begin
                    releaseOwner();
                    eBusy = 1'b0;
                end else begin
                    eBusy = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, step the model, and compare after the edge.
    task automatic applyStimulus(input logic srst, input logic clr,
                                 input logic [TW-1:0] clrT,
                                 input logic [NREQ-1:0] req,
                                 input logic [NREQ*TW-1:0] reqT,
                                 input logic [NREQ*WIDTH-1:0] d,
                                 input logic [NREQ*TW-1:0] dT);
        SRST  = srst;
        CLR   = clr;
        CLR_t = clrT;
        REQ   = req;
        REQ_t = reqT;
        D     = d;
        D_t   = dT;
        modelStep();
        @(negedge CLK);
        checkOutput("gnt",   32'(GNT),   32'(eGnt));
        checkOutput("gnt_t", 32'(GNT_t), 32'(eGntT));
        checkOutput("q",     32'(Q),     32'(eQ));
        checkOutput("q_t",   32'(Q_t),   32'(eQT));
        checkOutput("busy",  32'(BUSY),  32'(eBusy));
    endtask

    initial begin
        logic [NREQ-1:0]       curReq;
        logic [NREQ*TW-1:0]    rt;
        logic [NREQ*TW-1:0]    dt;
        logic [NREQ*WIDTH-1:0] dv;
        logic [1:0]            xWord;
        logic                  rClr;
        logic                  rRst;

        compared   = 0;
        mismatched = 0;
        SRST  = 1'b1;
        CLR   = 1'b0;
        CLR_t = '0;
        REQ   = '0;
        REQ_t = '0;
        D     = '0;
        D_t   = '0;
        modelReset();

        // Reset state
        applyStimulus(1'b1, 1'b0, '0, '0, '0, '0, '0);
        checkOutput("rst_q",    32'(Q),    32'd0);
        checkOutput("rst_busy", 32'(BUSY), 32'd0);

        // Single requester 0: grant one cycle later, write the cycle after
        rt = '0; rt[31:0] = 32'h20;
        dt = '0; dt[31:0] = 32'h1;
        dv = '0; dv[1:0]  = 2'd2;
        applyStimulus(1'b0, 1'b0, '0, 4'b0001, rt, dv, dt);
        checkOutput("gnt_first", 32'(GNT), 32'h1);
        applyStimulus(1'b0, 1'b0, '0, 4'b0001, rt, dv, dt);
        checkOutput("q_first",   32'(Q),   32'd2);
        checkOutput("qt_first",  32'(Q_t), 32'h21);
        applyStimulus(1'b0, 1'b0, '0, 4'b0000, '0, dv, dt);

        // Owner 1 preempted by a clear; next grant goes to requester 2
        dv = '0; dv[3:2] = 2'd1;
        applyStimulus(1'b0, 1'b0, '0, 4'b0010, '0, dv, '0);
        checkOutput("gnt_own1", 32'(GNT), 32'h2);
        applyStimulus(1'b0, 1'b0, '0, 4'b0010, '0, dv, '0);
        applyStimulus(1'b0, 1'b1, 32'h4, 4'b0110, '0, dv, '0);
        checkOutput("q_nowrite", 32'(Q),   32'd1);
        checkOutput("gnt_pre",   32'(GNT), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h4, 4'b0110, '0, dv, '0);
        checkOutput("q_clr",  32'(Q),   32'd3);
        checkOutput("qt_clr", 32'(Q_t), 32'h4);
        applyStimulus(1'b0, 1'b0, '0, 4'b0110, '0, dv, '0);
        checkOutput("gnt_after_clr", 32'(GNT), 32'h4);
        applyStimulus(1'b0, 1'b0, '0, 4'b0000, '0, dv, '0);

        // Grant taint covers losing requester 2, and reaches Q_t
        applyStimulus(1'b1, 1'b0, '0, '0, '0, '0, '0);
        rt = '0; rt[2*TW +: TW] = 32'h10;
        dt = '0; dt[31:0] = 32'h2;
        dv = '0; dv[1:0] = 2'd1;
        applyStimulus(1'b0, 1'b0, '0, 4'b0101, rt, dv, dt);
        checkOutput("gntt_or", 32'(GNT_t), 32'h10);
        applyStimulus(1'b0, 1'b0, '0, 4'b0101, rt, dv, dt);
        checkOutput("qt_or", 32'(Q_t), 32'h12);

        // Unknown data bits on the owner's slice drop the taint
        xWord = 2'bx0;
        dv[1:0] = xWord;
        applyStimulus(1'b0, 1'b0, '0, 4'b0101, rt, dv, dt);
        checkOutput("qt_x", 32'(Q_t), $isunknown(xWord) ? 32'h0 : 32'h12);
        dv[1:0] = 2'd1;
        applyStimulus(1'b0, 1'b0, '0, 4'b0000, '0, dv, dt);

        // Full contention: 8 writes, an idle gap, then requester 1
        applyStimulus(1'b1, 1'b0, '0, '0, '0, '0, '0);
        for (int c = 0; c < 9; c++)
            applyStimulus(1'b0, 1'b0, '0, 4'b1111, '0, 8'hE4, '0);
        checkOutput("gap_gnt",  32'(GNT),  32'h0);
        checkOutput("gap_busy", 32'(BUSY), 32'h0);
        applyStimulus(1'b0, 1'b0, '0, 4'b1111, '0, 8'hE4, '0);
        checkOutput("rot_gnt", 32'(GNT), 32'h2);
        applyStimulus(1'b0, 1'b0, '0, 4'b1111, '0, 8'hE4, '0);
        checkOutput("rot_q", 32'(Q), 32'd1);

        // Reset in the middle of a tenure restarts at requester 0
        applyStimulus(1'b1, 1'b0, '0, 4'b1111, '0, 8'hE4, '0);
        checkOutput("mid_rst_gnt", 32'(GNT), 32'h0);
        checkOutput("mid_rst_q",   32'(Q),   32'h0);
        applyStimulus(1'b0, 1'b0, '0, 4'b1111, '0, 8'hE4, '0);
        checkOutput("regrant", 32'(GNT), 32'h1);

        // Random traffic
        curReq = 4'b1011;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0)
                curReq[$urandom_range(0, NREQ - 1)] ^= 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                rt[i*TW +: TW] = ($urandom_range(0, 2) == 0) ? (TW'(1) << $urandom_range(0, TW - 1)) : '0;
                dt[i*TW +: TW] = ($urandom_range(0, 2) == 0) ? (TW'(1) << $urandom_range(0, TW - 1)) : '0;
            end
            dv   = NREQ*WIDTH'($urandom);
            rClr = ($urandom_range(0, 15) == 0);
            rRst = ($urandom_range(0, 199) == 0);
            applyStimulus(rRst, rClr, TW'(1) << $urandom_range(0, TW - 1),
                          curReq, rt, dv, dt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
